// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_sup_state_t;

    localparam int RETRY_W = 8;

    // Largest of three values, used to size the shared sequencing counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the local clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies its locked output and
// releases core reset once lock has held long enough. Re-sequences on lock
// loss or lock timeout.
// Build option: define PLL_SUPERVISOR_GIVEUP_EN to enter FAIL after
// MAX_RETRIES timeouts; otherwise it retries forever and pll_fail stays 0.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 74250,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 8
) (
    input  logic               clk_74a,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               pll_reset_req,
    output logic               pll_rst,
    output logic               core_reset_n,
    output logic               pll_ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count,
    output logic               pll_fail
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

`ifdef PLL_SUPERVISOR_GIVEUP_EN
    localparam bit GIVEUP_EN = 1'b1;
`else
    localparam bit GIVEUP_EN = 1'b0;
`endif

    pll_sup_state_t     state;
    pll_sup_state_t     state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [RETRY_W-1:0] retry_sat;
    logic               lost_nxt;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign retry_sat = (retry_count == '1) ? retry_count : retry_count + 1'b1;

    // Next-state, retry and lock-loss decisions; a reset request overrides everything.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        lost_nxt  = 1'b0;
        if (pll_reset_req) begin
            state_nxt = RESET_PLL;
            if (state == FAIL) begin
                retry_nxt = '0;
            end
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == LOCK_LAST) begin
                        retry_nxt = retry_sat;
                        state_nxt = (GIVEUP_EN && (retry_sat >= RETRY_LIMIT)) ? FAIL : RESET_PLL;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = RESET_PLL;
                        lost_nxt  = 1'b1;
                    end
                end
                FAIL: begin
                    state_nxt = FAIL;
                end
                default: begin
                    state_nxt = RESET_PLL;
                end
            endcase
        end
    end

    // Shared counter restarts on every state change and only runs in timed states.
    always_comb begin
        cnt_nxt = cnt;
        if (pll_reset_req || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if ((state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // State register with outputs decoded from the next state so they move together.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            pll_ready    <= 1'b0;
            lock_lost    <= 1'b0;
            retry_count  <= '0;
`ifdef PLL_SUPERVISOR_GIVEUP_EN
            pll_fail     <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pll_rst      <= (state_nxt == RESET_PLL);
            core_reset_n <= (state_nxt == RUN);
            pll_ready    <= (state_nxt == RUN);
            lock_lost    <= lost_nxt;
            retry_count  <= retry_nxt;
`ifdef PLL_SUPERVISOR_GIVEUP_EN
            pll_fail     <= (state_nxt == FAIL);
`endif
        end
    end

`ifndef PLL_SUPERVISOR_GIVEUP_EN
    assign pll_fail = 1'b0;
`endif

endmodule
